// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between an instruction-fetch
// port (A) and a load/store port (B); the grant is held until the memory responds.
module mem_port_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            a_read,
    input  logic            a_write,
    input  logic [DW/8-1:0] a_wmask,
    input  logic [AW-1:0]   a_address,
    input  logic [DW-1:0]   a_wdata,
    output logic            a_resp,
    output logic [DW-1:0]   a_rdata,
    input  logic            b_read,
    input  logic            b_write,
    input  logic [DW/8-1:0] b_wmask,
    input  logic [AW-1:0]   b_address,
    input  logic [DW-1:0]   b_wdata,
    output logic            b_resp,
    output logic [DW-1:0]   b_rdata,
    output logic            mem_read,
    output logic            mem_write,
    output logic [DW/8-1:0] mem_wmask,
    output logic [AW-1:0]   mem_address,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_resp,
    input  logic [DW-1:0]   mem_rdata,
    output logic [CW-1:0]   contention_count
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_A = 2'd1;
    localparam logic [1:0] GRANT_B = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] count_q, count_d;
    logic          req_a, req_b, contend;

    assign req_a = a_read | a_write;
    assign req_b = b_read | b_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_wmask    = '0;
        mem_address  = '0;
        mem_wdata    = '0;
        a_resp       = 1'b0;
        b_resp       = 1'b0;
        a_rdata      = '0;
        b_rdata      = '0;
        case (state_q)
            IDLE: begin
                // On a tie, the port that was not served last goes next
                if (req_a && req_b)
                    state_d = last_grant_q ? GRANT_A : GRANT_B;
                else if (req_a)
                    state_d = GRANT_A;
                else if (req_b)
                    state_d = GRANT_B;
            end
            GRANT_A: begin
                a_rdata = mem_rdata;
                if (req_a) begin
                    mem_write   = a_write;
                    mem_read    = a_read & ~a_write;
                    mem_wmask   = a_wmask;
                    mem_address = a_address;
                    mem_wdata   = a_wdata;
                    a_resp      = mem_resp;
                    if (mem_resp) begin
                        state_d      = IDLE;
                        last_grant_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_B: begin
                b_rdata = mem_rdata;
                if (req_b) begin
                    mem_write   = b_write;
                    mem_read    = b_read & ~b_write;
                    mem_wmask   = b_wmask;
                    mem_address = b_address;
                    mem_wdata   = b_wdata;
                    b_resp      = mem_resp;
                    if (mem_resp) begin
                        state_d      = IDLE;
                        last_grant_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign contend = ((state_q == GRANT_A) && req_b) ||
                     ((state_q == GRANT_B) && req_a) ||
                     ((state_q == IDLE) && req_a && req_b);

    always_comb begin
        count_d = count_q;
        if (contend && (count_q != {CW{1'b1}}))
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
        end
    end

    assign contention_count = count_q;
endmodule
